key_event_selector: RTL
=======================

Name: key_event_selector

Overview:
- Parametrised successor to the four-key input selector in the term-project datapath.
- Takes N raw push-button inputs and synchronises and debounces each one.
- Detects press edges, queues them in a pending mask and issues them one at a time through a valid/ready event port, lowest index first.
- Also provides a level-style selection output (momentary or latched mode) to drive downstream display/encoder logic.

Parameters:
N_KEYS, 4, number of key inputs (2..16).
IDX_W, 2, width of key index; must equal ceil(log2(N_KEYS)).
DEBOUNCE, 4, consecutive stable cycles required to accept a level change (1..255).
CNT_W, 8, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
keys  in  N_KEYS  raw asynchronous key levels, 1 = pressed
mode  in  1  0 = momentary selection, 1 = latched selection
evt_ready  in  1  consumer accepts event
clr_ovr  in  1  clears sticky overrun flag
evt_valid  out  1  event slot holds an unconsumed press
evt_idx  out  IDX_W  index of key for event in slot
held  out  N_KEYS  debounced key levels
sel_idx  out  IDX_W  current selected key index
sel_any  out  1  sel_idx is meaningful
ovr  out  1  sticky: a press was lost

Behaviour:
- Reset:
  - One clock and one reset: clk, rising edge; rst synchronous, active-high.
  - While rst=1 at a clock edge, all state clears: sync flops, counters, held, pending, slot, last-latched index, ovr.
  - All outputs read 0 from that edge on.
  - Reset mid-operation discards any pending or in-slot events with no handshake.
- Synchroniser: 2-flop per key. sync[i] lags keys[i] by 2 cycles.
- Debounce, per key:
  - If sync[i]==held[i], the counter resets to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE-1 while still differing, held[i] toggles on that edge and the counter resets.
  - A glitch shorter than DEBOUNCE cycles never changes held.
  - Latency from a clean keys edge to held: 2+DEBOUNCE cycles.
- Edge detect: press[i] = held[i] & ~held_d[i], one-cycle pulse one cycle after held rises. Releases generate no event.
- Pending mask:
  - press[i] sets pending[i].
  - If pending[i] is already 1 and not being loaded this cycle, the press is lost and ovr sets.
  - If pending[i] is loaded into the slot in the same cycle that press[i] occurs, pending[i] stays 1 and there is no overrun.
- Event slot:
  - The slot is free when evt_valid=0 or (evt_valid & evt_ready).
  - When free and pending≠0: load evt_idx = lowest set index, evt_valid=1, clear that pending bit.
  - Back-to-back events issue with no bubble.
  - While evt_valid=1 and evt_ready=0, evt_idx is held stable.
  - evt_valid never drops without a transfer, except on rst.
- Overrun: clr_ovr clears ovr. If set and clear occur in the same cycle, set wins.
- Selection:
  - mode=0: sel_any = |held; sel_idx = lowest set index of held, else 0. Purely registered from held, so valid the cycle after held changes.
  - mode=1: on each transfer (evt_valid & evt_ready), latch evt_idx as sel_idx and set sel_any=1. It holds until the next transfer or rst.
  - Switching mode takes effect the next cycle. The latched register keeps updating in both modes.
- Fully synchronous single clock domain; no combinational path from keys to any output.

Test Plan:
- Reset: rst held 3 cycles with keys=4'b1111 → all outputs 0; after release, held=4'b1111 at 2+4 cycles.
- Debounce: keys[1] pulses high for 3 cycles → held stays 0, no event. keys[1] held high 10 cycles → held[1]=1 at cycle 6, evt_valid=1 with evt_idx=1 at cycle 8.
- Simultaneous presses: keys 0 and 2 rise together, evt_ready=1 → events evt_idx=0 then evt_idx=2 on consecutive cycles, ovr=0.
- Backpressure/overrun: evt_ready=0, press key 3, release, press key 3 again → slot holds idx 3; second press sets pending[3]. Third press → ovr=1. clr_ovr together with a fourth press → ovr stays 1.
- Mode: mode=0 with held=4'b1010 → sel_idx=1, sel_any=1; release all → sel_any=0. mode=1 after transfer of idx 3 → sel_idx=3, sel_any=1 persists after release.
- Reset mid-operation: pending=4'b0110 and evt_valid=1, assert rst one cycle → evt_valid=0, pending empty, no further events without new presses.

Source files
------------

// File: rtl/key_event_selector.sv
// N-key input selector: synchronises and debounces raw key levels, queues
// press events behind a valid/ready port and drives a momentary/latched selection.
module key_event_selector #(
    parameter int N_KEYS   = 4,
    parameter int IDX_W    = 2,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys,
    input  logic              mode,
    input  logic              evt_ready,
    input  logic              clr_ovr,
    output logic              evt_valid,
    output logic [IDX_W-1:0]  evt_idx,
    output logic [N_KEYS-1:0] held,
    output logic [IDX_W-1:0]  sel_idx,
    output logic              sel_any,
    output logic              ovr
);

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_KEYS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];
    logic [N_KEYS-1:0] held_q, held_d;
    logic [N_KEYS-1:0] held_dly_q, held_dly_d;
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic              evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0]  evt_idx_q, evt_idx_d;
    logic [IDX_W-1:0]  lat_idx_q, lat_idx_d;
    logic              lat_any_q, lat_any_d;
    logic [IDX_W-1:0]  mom_idx_q, mom_idx_d;
    logic              mom_any_q, mom_any_d;
    logic              mode_q, mode_d;
    logic              ovr_q, ovr_d;

    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] grant;
    logic              slot_free;
    logic              load;
    logic              xfer;

    // NOTE: combinational logic uses blocking assignments with every output
    // given a default first, so no path leaves a latch behind.
    always_comb begin
        sync1_d    = keys;
        sync2_d    = sync1_q;
        held_d     = held_q;
        held_dly_d = held_q;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != held_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
                    held_d[i] = ~held_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        press     = held_q & ~held_dly_q;
        slot_free = ~evt_valid_q | evt_ready;
        load      = slot_free & (|pending_q);
        xfer      = evt_valid_q & evt_ready;
        grant     = load ? (pending_q & (~pending_q + N_KEYS'(1))) : '0;

        // A press on a bit leaving for the slot this cycle re-arms it instead of overrunning.
        pending_d = (pending_q & ~grant) | press;
        ovr_d     = (|(press & pending_q & ~grant)) | (ovr_q & ~clr_ovr);

        evt_valid_d = evt_valid_q;
        evt_idx_d   = evt_idx_q;
        if (load) begin
            evt_valid_d = 1'b1;
            evt_idx_d   = lowest_idx(pending_q);
        end else if (xfer) begin
            evt_valid_d = 1'b0;
        end

        lat_idx_d = xfer ? evt_idx_q : lat_idx_q;
        lat_any_d = lat_any_q | xfer;
        mom_idx_d = lowest_idx(held_q);
        mom_any_d = |held_q;
        mode_d    = mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            // NOTE: the debounce counters are per-key control state, not a
            // storage array, so each one is cleared explicitly on reset.
            for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
            held_q      <= '0;
            held_dly_q  <= '0;
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            lat_idx_q   <= '0;
            lat_any_q   <= 1'b0;
            mom_idx_q   <= '0;
            mom_any_q   <= 1'b0;
            mode_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            held_q      <= held_d;
            held_dly_q  <= held_dly_d;
            pending_q   <= pending_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            lat_idx_q   <= lat_idx_d;
            lat_any_q   <= lat_any_d;
            mom_idx_q   <= mom_idx_d;
            mom_any_q   <= mom_any_d;
            mode_q      <= mode_d;
            ovr_q       <= ovr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;
    assign held      = held_q;
    assign ovr       = ovr_q;
    assign sel_idx   = mode_q ? lat_idx_q : mom_idx_q;
    assign sel_any   = mode_q ? lat_any_q : mom_any_q;

endmodule
